// File: rtl/cpc_ram_upload.sv
// cpc_ram_upload: host-side RAM snapshot reader for the ioctl upload channel.
// Walks CPC main RAM in SDRAM or the Multiface Two RAM and serves one byte per ioctl_rd.
module cpc_ram_upload #(
    parameter logic [22:0] RAM_BASE = 23'h020000,
    parameter int unsigned RAM_AW   = 17,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic        ioctl_rd,
    output logic [7:0]  ioctl_din,
    output logic        busy,
    output logic        cpu_hold,
    output logic        err,
    input  logic        model,
    output logic        mem_oe,
    output logic [22:0] mem_addr,
    output logic        mem_bank,
    input  logic [7:0]  mem_dout,
    input  logic        mem_valid,
    output logic [12:0] mf2_addr,
    input  logic [7:0]  mf2_dout
);
    localparam int unsigned MF2_AW = 13;
    localparam int unsigned OFF_W  = RAM_AW + 1;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MF2  = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_READY} state_t;
    typedef enum logic [1:0] {RG_MAIN, RG_MF2, RG_NONE} region_t;

    state_t             r_state;
    region_t            r_region;
    logic               r_upload_d;
    logic               r_model;
    logic [RAM_AW-1:0]  r_off;
    logic               r_ovf;
    logic               r_pending;
    logic [CNT_W-1:0]   r_wait_cnt;

    logic               w_upload_rise;
    logic               w_upload_fall;
    logic               w_rd_busy;
    logic               w_mf2_oob;
    logic [OFF_W-1:0]   w_off_inc;
    logic [22:0]        w_mem_addr;
    region_t            w_start_region;
    logic               w_unused;

    assign w_upload_rise  = ioctl_upload & ~r_upload_d;
    assign w_upload_fall  = ~ioctl_upload & r_upload_d;
    assign w_rd_busy      = ioctl_rd & ((r_state == S_ISSUE) | (r_state == S_WAIT));
    assign w_off_inc      = {1'b0, r_off} + OFF_W'(1);
    assign w_mf2_oob      = r_ovf | (|r_off[RAM_AW-1:MF2_AW]);
    assign w_mem_addr     = RAM_BASE + 23'(r_off);
    assign w_start_region = (ioctl_index == 8'd0) ? RG_MAIN :
                            (ioctl_index == 8'd1) ? RG_MF2  : RG_NONE;
    assign w_unused       = ^ioctl_addr[24:RAM_AW];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_region   <= RG_NONE;
            // Treat the line as already high so a session needs a fresh rising edge.
            r_upload_d <= 1'b1;
            r_model    <= 1'b0;
            r_off      <= '0;
            r_ovf      <= 1'b0;
            r_pending  <= 1'b0;
            r_wait_cnt <= '0;
            ioctl_din  <= 8'hFF;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            err        <= 1'b0;
            mem_oe     <= 1'b0;
            mem_addr   <= '0;
            mem_bank   <= 1'b0;
            mf2_addr   <= '0;
        end else begin
            r_upload_d <= ioctl_upload;
            if (w_upload_fall) begin
                r_state   <= S_IDLE;
                r_pending <= 1'b0;
                busy      <= 1'b0;
                cpu_hold  <= 1'b0;
                mem_oe    <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_upload_rise) begin
                            r_off     <= ioctl_addr[RAM_AW-1:0];
                            r_ovf     <= 1'b0;
                            r_region  <= w_start_region;
                            r_model   <= model;
                            r_pending <= 1'b0;
                            err       <= 1'b0;
                            cpu_hold  <= 1'b1;
                            busy      <= 1'b1;
                            if (w_start_region == RG_MF2) begin
                                mf2_addr <= ioctl_addr[MF2_AW-1:0];
                            end
                            r_state   <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        r_wait_cnt <= '0;
                        unique case (r_region)
                            RG_MAIN: begin
                                if (r_ovf) begin
                                    ioctl_din <= 8'hFF;
                                    busy      <= 1'b0;
                                    r_state   <= S_READY;
                                end else begin
                                    mem_addr  <= w_mem_addr;
                                    mem_bank  <= r_model;
                                    mem_oe    <= 1'b1;
                                    r_state   <= S_WAIT;
                                end
                            end
                            RG_MF2: begin
                                if (w_mf2_oob) begin
                                    ioctl_din <= 8'hFF;
                                    busy      <= 1'b0;
                                    r_state   <= S_READY;
                                end else begin
                                    mf2_addr  <= r_off[MF2_AW-1:0];
                                    r_state   <= S_WAIT;
                                end
                            end
                            default: begin
                                ioctl_din <= 8'hFF;
                                busy      <= 1'b0;
                                r_state   <= S_READY;
                            end
                        endcase
                    end
                    S_WAIT: begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        if ((r_region == RG_MAIN) && mem_valid) begin
                            ioctl_din <= mem_dout;
                            mem_oe    <= 1'b0;
                            busy      <= 1'b0;
                            r_state   <= S_READY;
                        end else if ((r_region == RG_MF2) && (r_wait_cnt == CNT_MF2)) begin
                            ioctl_din <= mf2_dout;
                            busy      <= 1'b0;
                            r_state   <= S_READY;
                        end else if (r_wait_cnt == CNT_LAST) begin
                            ioctl_din <= 8'hFF;
                            err       <= 1'b1;
                            mem_oe    <= 1'b0;
                            busy      <= 1'b0;
                            r_state   <= S_READY;
                        end
                    end
                    S_READY: begin
                        // A strobe queued during the fetch restarts immediately.
                        if (ioctl_rd || r_pending) begin
                            r_off     <= w_off_inc[RAM_AW-1:0];
                            r_ovf     <= r_ovf | w_off_inc[RAM_AW];
                            r_pending <= 1'b0;
                            busy      <= 1'b1;
                            if (r_region == RG_MF2) begin
                                mf2_addr <= w_off_inc[MF2_AW-1:0];
                            end
                            r_state   <= S_ISSUE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase

                if (w_rd_busy) begin
                    if (r_pending) begin
                        err <= 1'b1;
                    end else begin
                        r_pending <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cpc_ram_upload.sv
// tb_cpc_ram_upload: directed bench for cpc_ram_upload with a 5-cycle SDRAM
// model (data = address low byte) and a registered MF2 RAM model.
module tb_cpc_ram_upload;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic        ioctl_rd = 1'b0;
    logic        model = 1'b0;
    logic [7:0]  ioctl_din;
    logic        busy;
    logic        cpu_hold;
    logic        err;
    logic        mem_oe;
    logic [22:0] mem_addr;
    logic        mem_bank;
    logic [7:0]  mem_dout;
    logic        mem_valid;
    logic [12:0] mf2_addr;
    logic [7:0]  mf2_dout = 8'd0;

    logic        sd_en = 1'b1;
    logic        sd_valid = 1'b0;
    logic [7:0]  sd_dout = 8'd0;
    int          sd_cnt = 0;
    logic        inj_valid = 1'b0;
    logic [7:0]  inj_dout = 8'd0;
    logic [7:0]  mf2_mem [0:8191];

    int          n_total = 0;
    int          n_bad = 0;

    cpc_ram_upload dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_addr   (ioctl_addr),
        .ioctl_rd     (ioctl_rd),
        .ioctl_din    (ioctl_din),
        .busy         (busy),
        .cpu_hold     (cpu_hold),
        .err          (err),
        .model        (model),
        .mem_oe       (mem_oe),
        .mem_addr     (mem_addr),
        .mem_bank     (mem_bank),
        .mem_dout     (mem_dout),
        .mem_valid    (mem_valid),
        .mf2_addr     (mf2_addr),
        .mf2_dout     (mf2_dout)
    );

    always #5 clk_sys = ~clk_sys;

    assign mem_valid = sd_valid | inj_valid;
    assign mem_dout  = inj_valid ? inj_dout : sd_dout;

    // SDRAM: answers a held mem_oe after five sampled cycles with mem_addr[7:0].
    always @(posedge clk_sys) begin
        if (mem_oe && sd_en && !sd_valid) begin
            if (sd_cnt == 4) begin
                sd_valid <= 1'b1;
                sd_dout  <= mem_addr[7:0];
                sd_cnt   <= 0;
            end else begin
                sd_cnt <= sd_cnt + 1;
            end
        end else begin
            sd_valid <= 1'b0;
            if (!mem_oe) sd_cnt <= 0;
        end
    end

    always @(posedge clk_sys) mf2_dout <= mf2_mem[mf2_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic wait_ready(input string tag, input int limit, output int cyc, output logic saw_oe);
        cyc = 0;
        saw_oe = mem_oe;
        while (busy !== 1'b0 && cyc < limit) begin
            tick(1);
            cyc++;
            saw_oe = saw_oe | mem_oe;
        end
        if (busy !== 1'b0) check({tag, "_busy_stuck"}, 32'(busy), 32'd0);
    endtask

    task automatic start(input logic [7:0] idx, input logic [24:0] addr, input logic mdl);
        ioctl_index  = idx;
        ioctl_addr   = addr;
        model        = mdl;
        ioctl_upload = 1'b1;
        tick(1);
    endtask

    task automatic stop();
        ioctl_upload = 1'b0;
        tick(1);
    endtask

    task automatic pulse_rd();
        ioctl_rd = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_din"},      32'(ioctl_din), 32'hFF);
        check({tag, "_busy"},     32'(busy),      32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold),  32'd0);
        check({tag, "_err"},      32'(err),       32'd0);
        check({tag, "_mem_oe"},   32'(mem_oe),    32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr),  32'd0);
        check({tag, "_mem_bank"}, 32'(mem_bank),  32'd0);
        check({tag, "_mf2_addr"}, 32'(mf2_addr),  32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   cyc2;
        logic saw;

        for (int i = 0; i < 8192; i++) mf2_mem[i] = 8'(i) ^ 8'h3C;
        mf2_mem[13'h1FCF] = 8'h5A;
        mf2_mem[13'h1FD0] = 8'hA5;

        reset = 1'b1;
        tick(3);
        check_reset_values("rst");
        reset = 1'b0;
        tick(2);

        // Main RAM from offset 0, bank 1
        start(8'd0, 25'd0, 1'b1);
        check("t1_hold", 32'(cpu_hold), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        tick(1);
        check("t1_oe", 32'(mem_oe), 32'd1);
        check("t1_addr0", 32'(mem_addr), 32'h020000);
        check("t1_bank", 32'(mem_bank), 32'd1);
        wait_ready("t1_b0", 50, cyc, saw);
        check("t1_lat", 32'(cyc), 32'd6);
        check("t1_din0", 32'(ioctl_din), 32'h00);
        for (int k = 1; k <= 4; k++) begin
            pulse_rd();
            check($sformatf("t1_busy%0d", k), 32'(busy), 32'd1);
            tick(1);
            check($sformatf("t1_addr%0d", k), 32'(mem_addr), 32'h020000 + 32'(k));
            wait_ready("t1_bk", 50, cyc, saw);
            check($sformatf("t1_din%0d", k), 32'(ioctl_din), 32'(k));
        end
        check("t1_err", 32'(err), 32'd0);
        stop();
        check("t1_end_hold", 32'(cpu_hold), 32'd0);
        check("t1_end_busy", 32'(busy), 32'd0);
        tick(1);

        // Last byte of main RAM, then past the end
        start(8'd0, 25'h1FFFF, 1'b0);
        tick(1);
        check("t2_addr", 32'(mem_addr), 32'h03FFFF);
        wait_ready("t2_b0", 50, cyc, saw);
        check("t2_din0", 32'(ioctl_din), 32'hFF);
        pulse_rd();
        wait_ready("t2_b1", 50, cyc, saw);
        check("t2_lat", 32'(cyc), 32'd1);
        check("t2_no_oe", 32'(saw), 32'd0);
        check("t2_din1", 32'(ioctl_din), 32'hFF);
        stop();
        tick(1);

        // Multiface Two RAM
        start(8'd1, 25'h1FCF, 1'b0);
        check("t3_mf2addr", 32'(mf2_addr), 32'h1FCF);
        wait_ready("t3_b0", 50, cyc, saw);
        check("t3_lat0", 32'(cyc), 32'd3);
        check("t3_din0", 32'(ioctl_din), 32'h5A);
        pulse_rd();
        wait_ready("t3_b1", 50, cyc2, saw);
        check("t3_b2b", 32'(1 + cyc2), 32'd4);
        check("t3_din1", 32'(ioctl_din), 32'hA5);
        check("t3_no_oe", 32'(saw | mem_oe), 32'd0);
        stop();
        tick(1);

        // Two strobes during one WAIT: first queued, second dropped
        start(8'd0, 25'h10, 1'b0);
        tick(1);
        pulse_rd();
        tick(1);
        pulse_rd();
        check("t4_err_set", 32'(err), 32'd1);
        wait_ready("t4_b0", 50, cyc, saw);
        check("t4_din0", 32'(ioctl_din), 32'h10);
        tick(1);
        check("t4_requeue", 32'(busy), 32'd1);
        wait_ready("t4_b1", 50, cyc, saw);
        check("t4_din1", 32'(ioctl_din), 32'h11);
        tick(3);
        check("t4_idle_busy", 32'(busy), 32'd0);
        check("t4_idle_din", 32'(ioctl_din), 32'h11);
        check("t4_err_hold", 32'(err), 32'd1);
        stop();
        tick(1);

        // Empty region; new session clears err
        start(8'd2, 25'd0, 1'b0);
        check("t4_err_clr", 32'(err), 32'd0);
        check("t4e_busy", 32'(busy), 32'd1);
        wait_ready("t4e", 50, cyc, saw);
        check("t4e_lat", 32'(cyc), 32'd1);
        check("t4e_din", 32'(ioctl_din), 32'hFF);
        stop();
        tick(1);

        // SDRAM never answers
        start(8'd0, 25'h5, 1'b0);
        wait_ready("t5_b0", 50, cyc, saw);
        check("t5_din0", 32'(ioctl_din), 32'h05);
        sd_en = 1'b0;
        pulse_rd();
        wait_ready("t5_b1", 400, cyc2, saw);
        check("t5_to_lat", 32'(cyc2), 32'd256);
        check("t5_din", 32'(ioctl_din), 32'hFF);
        check("t5_err", 32'(err), 32'd1);
        check("t5_oe", 32'(mem_oe), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        sd_en = 1'b1;
        stop();
        tick(1);

        // Abort during WAIT, then a late mem_valid
        start(8'd0, 25'h40, 1'b0);
        wait_ready("t6_b0", 50, cyc, saw);
        check("t6_din0", 32'(ioctl_din), 32'h40);
        pulse_rd();
        tick(1);
        check("t6_oe", 32'(mem_oe), 32'd1);
        ioctl_upload = 1'b0;
        tick(1);
        check("t6_hold", 32'(cpu_hold), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_oe_off", 32'(mem_oe), 32'd0);
        sd_en     = 1'b0;
        inj_valid = 1'b1;
        inj_dout  = 8'h77;
        tick(1);
        inj_valid = 1'b0;
        tick(1);
        check("t6_din_kept", 32'(ioctl_din), 32'h40);
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_idle_oe", 32'(mem_oe), 32'd0);
        sd_en = 1'b1;

        // Reset during WAIT with upload still high
        start(8'd0, 25'h41, 1'b1);
        wait_ready("t7_b0", 50, cyc, saw);
        check("t7_din0", 32'(ioctl_din), 32'h41);
        pulse_rd();
        tick(1);
        check("t7_oe", 32'(mem_oe), 32'd1);
        reset = 1'b1;
        tick(1);
        check_reset_values("t7_rst");
        reset = 1'b0;
        tick(4);
        check("t7_no_restart_hold", 32'(cpu_hold), 32'd0);
        check("t7_no_restart_busy", 32'(busy), 32'd0);
        ioctl_upload = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
